apb_gpio_ctrl: RTL and testbench
================================

// Module: apb_gpio_ctrl
// PURPOSE
//  Register-mapped GPIO controller that drives the gpio_out/gpio_dir/gpio_cfg inputs of the pad
//  control stage and consumes its gpio_in output. Provides:
//   - a 2-flop input synchronizer;
//   - per-pin edge-detect interrupts with sticky status;
//   - atomic set/clear of output bits;
//   - a per-pin 6-bit pad configuration register.
//  Sits between the SoC peripheral APB bus and the pad control stage.
// PARAMETERS
//  NPINS   32  number of GPIO pins (1..32)
//  CFG_W   6   pad configuration bits per pin
// PORTS
//  clk_i          in   1            single clock, rising-edge
//  rst_i          in   1            reset, synchronous, active-high
//  paddr_i        in   12           APB byte address (bits [1:0] ignored)
//  pwdata_i       in   32           APB write data
//  pwrite_i       in   1            APB write(1)/read(0)
//  psel_i         in   1            APB select
//  penable_i      in   1            APB enable (access phase)
//  prdata_o       out  32           APB read data, valid in access phase
//  pready_o       out  1            always 1 (zero wait states)
//  pslverr_o      out  1            1 in access phase to an unmapped address
//  gpio_in_i      in   NPINS        raw pad inputs (asynchronous)
//  gpio_out_o     out  NPINS        output values to pads
//  gpio_dir_o     out  NPINS        1 = pin drives (output enable)
//  gpio_cfg_o     out  NPINS*CFG_W  packed [NPINS-1:0][CFG_W-1:0] pad config
//  interrupt_o    out  1            OR of (INTSTATUS & INTEN)
// BEHAVIOUR
//  Access and reset
//   - Access = psel_i & penable_i; all register side effects occur on the clk_i edge ending access.
//   - Reset: every register, both synchronizer stages and the edge-history flop go to 0.
//     gpio_out_o=0, gpio_dir_o=0 (all inputs), gpio_cfg_o=0, interrupt_o=0, prdata_o=0, pslverr_o=0.
//  Register map (bits above NPINS-1 read 0, writes ignored)
//   0x00 DIR       RW
//   0x04 IN        RO   synchronized input (sync2)
//   0x08 OUT       RW
//   0x0C OUT_SET   WO   OUT |= wdata; reads 0
//   0x10 OUT_CLR   WO   OUT &= ~wdata; reads 0
//   0x14 INTEN     RW
//   0x18 INTTYPE0  RW
//   0x1C INTTYPE1  RW
//   0x20 INTSTATUS RO   clear-on-read
//   0x40+4*k       PADCFG k, k<NPINS, bits[CFG_W-1:0] RW
//   - Any other address: pslverr_o=1, prdata_o=0, no side effect.
//  Synchronizer and edge detection
//   - sync1<=gpio_in_i; sync2<=sync1; prev<=sync2.
//   - rise = sync2&~prev; fall = ~sync2&prev.
//   - Per-pin type {INTTYPE1,INTTYPE0}: 00 rise, 01 fall, 1x both edges.
//   - Edge condition for pin i (selected edge type present in its rise/fall bit) sets INTSTATUS[i]
//     on the next edge. Detection is independent of INTEN: status is recorded, INTEN only masks
//     interrupt_o.
//  Latency
//   - Pin change sampled at edge N: IN reads new value after edge N+1.
//   - INTSTATUS set at edge N+2; interrupt_o high after edge N+2 (combinational OR of flops).
//  Clear-on-read
//   - Read access to 0x20 returns the current status, then clears the bits returned.
//   - A new edge for the same pin in the same cycle wins: that bit stays 1.
//  Pad direction
//   - Input sync/edge logic runs regardless of DIR.
//   - Pads driven as outputs also loop back through IN and can raise interrupts.
//  Reset mid-operation
//   - rst_i during an access aborts it: no write lands, no status clears.
//   - Histories reset, so no spurious edge is reported on the first post-reset cycle:
//     prev=sync2=0, so a pin held high after reset reports a rise only once it propagates.
//  Other rules
//   - prdata_o is driven only during access to a readable address, else 0.
//   - pready_o is tied high.
// TESTING
//  T1 reset: assert rst_i 2 cycles -> all outputs 0, DIR/OUT/INTEN/PADCFG read 0x0.
//  T2 OUT atomics: write OUT=0x0000_00F0, OUT_SET=0x0000_0003, OUT_CLR=0x0000_0010
//     -> gpio_out_o=0x0000_00E3, reads back 0x000000E3.
//  T3 rise IRQ: INTEN=0x1, INTTYPE=00, pin0 0->1 sampled edge N
//     -> INTSTATUS=0x1 and interrupt_o=1 after edge N+2.
//     -> read 0x20 returns 0x1, next read returns 0x0, interrupt_o=0.
//  T4 both-edge + masked: pin5 type 1x, INTEN=0, pulse pin5 high 4 cycles
//     -> INTSTATUS bit5=1, interrupt_o stays 0.
//     -> set INTEN bit5 -> interrupt_o=1 next cycle.
//  T5 clear/set collision: schedule read of 0x20 on the exact cycle a new pin3 rise sets status
//     -> read returns the old value and bit3 remains 1 afterwards.
//  T6 PADCFG/error: write 0x40+4*7=0x3F -> gpio_cfg_o[7]=6'h3F, others 0.
//     -> access 0x300 -> pslverr_o=1, prdata_o=0, no register change.

Source files
------------

// File: rtl/apb_gpio_ctrl.sv
// APB-mapped GPIO controller: output/direction registers with atomic set/clear,
// 2-flop input synchronizer, per-pin edge interrupts with clear-on-read status, pad config.
module apb_gpio_ctrl #(
  parameter int NPINS = 32,
  parameter int CFG_W = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [11:0]              paddr_i,
  input  logic [31:0]              pwdata_i,
  input  logic                     pwrite_i,
  input  logic                     psel_i,
  input  logic                     penable_i,
  output logic [31:0]              prdata_o,
  output logic                     pready_o,
  output logic                     pslverr_o,
  input  logic [NPINS-1:0]         gpio_in_i,
  output logic [NPINS-1:0]         gpio_out_o,
  output logic [NPINS-1:0]         gpio_dir_o,
  output logic [NPINS*CFG_W-1:0]   gpio_cfg_o,
  output logic                     interrupt_o
);

  localparam logic [9:0] A_DIR   = 10'd0;
  localparam logic [9:0] A_IN    = 10'd1;
  localparam logic [9:0] A_OUT   = 10'd2;
  localparam logic [9:0] A_SET   = 10'd3;
  localparam logic [9:0] A_CLR   = 10'd4;
  localparam logic [9:0] A_INTEN = 10'd5;
  localparam logic [9:0] A_TYPE0 = 10'd6;
  localparam logic [9:0] A_TYPE1 = 10'd7;
  localparam logic [9:0] A_STAT  = 10'd8;
  localparam logic [9:0] A_PAD   = 10'd16;

  logic [9:0]       word_addr;
  logic             access;
  logic             wr_en;
  logic             rd_en;
  logic             reg_hit;
  logic             pad_hit;
  logic [NPINS-1:0] wdata;
  logic             unused_bits;

  logic [NPINS-1:0] dir_reg, dir_next;
  logic [NPINS-1:0] out_reg, out_next;
  logic [NPINS-1:0] inten_reg, inten_next;
  logic [NPINS-1:0] type0_reg, type0_next;
  logic [NPINS-1:0] type1_reg, type1_next;
  logic [NPINS-1:0] status_reg, status_next;
  logic [NPINS-1:0] sync1_reg, sync2_reg, prev_reg;
  logic [NPINS-1:0] rise, fall, edge_hit;
  logic [NPINS-1:0] clr_mask;
  logic [CFG_W-1:0] pad_rd;
  logic [31:0]      rd_word;
  logic             err;

  assign word_addr   = paddr_i[11:2];
  assign access      = psel_i & penable_i;
  assign wr_en       = access & pwrite_i;
  assign rd_en       = access & ~pwrite_i;
  assign wdata       = pwdata_i[NPINS-1:0];
  assign reg_hit     = (word_addr <= A_STAT);
  assign pad_hit     = (word_addr >= A_PAD) && (word_addr < 10'(16 + NPINS));
  assign unused_bits = ^{paddr_i[1:0], pwdata_i};

  assign rise = sync2_reg & ~prev_reg;
  assign fall = ~sync2_reg & prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NPINS; gi++) begin : g_pin
      logic [CFG_W-1:0] cfg_reg;
      logic             pad_we;

      // type1 selects both edges; otherwise type0 picks fall over rise
      assign edge_hit[gi] = type1_reg[gi] ? (rise[gi] | fall[gi])
                                          : (type0_reg[gi] ? fall[gi] : rise[gi]);

      assign pad_we = wr_en && (word_addr == 10'(16 + gi));

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cfg_reg <= '0;
        end else if (pad_we) begin
          cfg_reg <= pwdata_i[CFG_W-1:0];
        end
      end

      assign gpio_cfg_o[gi*CFG_W +: CFG_W] = cfg_reg;
    end
  endgenerate

  always_comb begin
    dir_next   = dir_reg;
    out_next   = out_reg;
    inten_next = inten_reg;
    type0_next = type0_reg;
    type1_next = type1_reg;
    if (wr_en) begin
      case (word_addr)
        A_DIR:   dir_next   = wdata;
        A_OUT:   out_next   = wdata;
        A_SET:   out_next   = out_reg | wdata;
        A_CLR:   out_next   = out_reg & ~wdata;
        A_INTEN: inten_next = wdata;
        A_TYPE0: type0_next = wdata;
        A_TYPE1: type1_next = wdata;
        default: ;
      endcase
    end
    // Clear only the bits being returned; a same-cycle edge re-sets its bit.
    clr_mask    = (rd_en && word_addr == A_STAT) ? status_reg : '0;
    status_next = (status_reg & ~clr_mask) | edge_hit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dir_reg    <= '0;
      out_reg    <= '0;
      inten_reg  <= '0;
      type0_reg  <= '0;
      type1_reg  <= '0;
      status_reg <= '0;
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      prev_reg   <= '0;
    end else begin
      dir_reg    <= dir_next;
      out_reg    <= out_next;
      inten_reg  <= inten_next;
      type0_reg  <= type0_next;
      type1_reg  <= type1_next;
      status_reg <= status_next;
      sync1_reg  <= gpio_in_i;
      sync2_reg  <= sync1_reg;
      prev_reg   <= sync2_reg;
    end
  end

  always_comb begin
    pad_rd = '0;
    for (int k = 0; k < NPINS; k++) begin
      if (word_addr == 10'(16 + k)) begin
        pad_rd = gpio_cfg_o[k*CFG_W +: CFG_W];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    err     = 1'b0;
    if (access) begin
      if (!(reg_hit || pad_hit)) begin
        err = 1'b1;
      end else if (!pwrite_i) begin
        case (word_addr)
          A_DIR:   rd_word[NPINS-1:0] = dir_reg;
          A_IN:    rd_word[NPINS-1:0] = sync2_reg;
          A_OUT:   rd_word[NPINS-1:0] = out_reg;
          A_INTEN: rd_word[NPINS-1:0] = inten_reg;
          A_TYPE0: rd_word[NPINS-1:0] = type0_reg;
          A_TYPE1: rd_word[NPINS-1:0] = type1_reg;
          A_STAT:  rd_word[NPINS-1:0] = status_reg;
          default: if (pad_hit) rd_word[CFG_W-1:0] = pad_rd;
        endcase
      end
    end
  end

  assign prdata_o    = rd_word;
  assign pslverr_o   = err;
  assign pready_o    = 1'b1;
  assign gpio_out_o  = out_reg;
  assign gpio_dir_o  = dir_reg;
  assign interrupt_o = |(status_reg & inten_reg);

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
// Bench for apb_gpio_ctrl: vector table for register access, hand sequences for
// interrupt timing corners, randomized traffic against a sampled-sequence model.
module tb_apb_gpio_ctrl;
  localparam int NPINS = 32;
  localparam int CFG_W = 6;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [11:0]            paddr;
  logic [31:0]            pwdata;
  logic                   pwrite;
  logic                   psel;
  logic                   penable;
  logic [31:0]            prdata;
  logic                   pready;
  logic                   pslverr;
  logic [NPINS-1:0]       gpio_in;
  logic [NPINS-1:0]       gpio_out;
  logic [NPINS-1:0]       gpio_dir;
  logic [NPINS*CFG_W-1:0] gpio_cfg;
  logic                   irq;

  int checks = 0;
  int errors = 0;

  apb_gpio_ctrl #(.NPINS(NPINS), .CFG_W(CFG_W)) dut (
    .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite),
    .psel_i(psel), .penable_i(penable), .prdata_o(prdata), .pready_o(pready),
    .pslverr_o(pslverr), .gpio_in_i(gpio_in), .gpio_out_o(gpio_out), .gpio_dir_o(gpio_dir),
    .gpio_cfg_o(gpio_cfg), .interrupt_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apb(input logic [11:0] a, input bit wr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    #1;
    rd  = prdata;
    err = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
    $display("apb %s addr=%h wdata=%h rdata=%h err=%b", wr ? "WR" : "RD", a, wd, rd, err);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic        e;
    apb(a, 1'b1, d, r, e);
    check("wr_err", e, 0);
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        e;
    apb(a, 1'b0, 32'h0, r, e);
    check(name, r, exp);
    check({name, "_err"}, e, 0);
  endtask

  task automatic do_reset();
    gpio_in = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_out"}, gpio_out, 0);
    check({tag, "_dir"}, gpio_dir, 0);
    check({tag, "_cfg"}, gpio_cfg, 0);
    check({tag, "_irq"}, irq, 0);
    check({tag, "_prdata"}, prdata, 0);
    check({tag, "_pslverr"}, pslverr, 0);
  endtask

  // model state for randomized phases
  logic [31:0]      m_dir, m_out, m_inten, m_t0, m_t1;
  logic [CFG_W-1:0] m_pad[NPINS];
  logic [NPINS*CFG_W-1:0] exp_cfg;

  initial begin
    logic [31:0] r;
    logic        e;
    logic [31:0] cur, v, pv, rise, fall, exp_st, d;
    int          k, op, len;

    do_reset();
    check_idle_zero("reset");
    check("pready", pready, 1);

    // register access vectors: {addr, wr, wdata, expected rdata, expected err}
    tbl.push_back('{12'h000, 1'b0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{12'h008, 1'b0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{12'h014, 1'b0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{12'h040, 1'b0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{12'h05C, 1'b0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{12'h008, 1'b1, 32'h0000_00F0, 32'h0, 1'b0});
    tbl.push_back('{12'h00C, 1'b1, 32'h0000_0003, 32'h0, 1'b0});
    tbl.push_back('{12'h010, 1'b1, 32'h0000_0010, 32'h0, 1'b0});
    tbl.push_back('{12'h008, 1'b0, 32'h0, 32'h0000_00E3, 1'b0});
    tbl.push_back('{12'h00C, 1'b0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{12'h010, 1'b0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{12'h05C, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0});
    tbl.push_back('{12'h05C, 1'b0, 32'h0, 32'h0000_003F, 1'b0});
    tbl.push_back('{12'h058, 1'b0, 32'h0, 32'h0, 1'b0});
    tbl.push_back('{12'h300, 1'b0, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{12'h300, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1});
    tbl.push_back('{12'h008, 1'b1, 32'h0000_00E3, 32'h0, 1'b0});
    tbl.push_back('{12'h024, 1'b0, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{12'h03C, 1'b1, 32'h1, 32'h0, 1'b1});
    tbl.push_back('{12'h0C0, 1'b0, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{12'h000, 1'b1, 32'hA5A5_5A5A, 32'h0, 1'b0});
    tbl.push_back('{12'h000, 1'b0, 32'h0, 32'hA5A5_5A5A, 1'b0});
    tbl.push_back('{12'h008, 1'b0, 32'h0, 32'h0000_00E3, 1'b0});

    foreach (tbl[i]) begin
      apb(tbl[i].addr, tbl[i].wr, tbl[i].wdata, r, e);
      if (!tbl[i].wr) check($sformatf("vec%0d_rdata", i), r, tbl[i].exp_rd);
      check($sformatf("vec%0d_err", i), e, tbl[i].exp_err);
    end
    check("t2_gpio_out", gpio_out, 32'h0000_00E3);
    check("t6_gpio_cfg", gpio_cfg, 192'h3F << (7 * CFG_W));
    check("t6_gpio_dir", gpio_dir, 32'hA5A5_5A5A);

    // rising edge on pin0: status and irq appear two edges after sampling
    wr(12'h014, 32'h1);
    @(negedge clk); gpio_in[0] = 1'b1;
    @(negedge clk); check("t3_irq_n0", irq, 0);
    @(negedge clk); check("t3_irq_n1", irq, 0);
    @(negedge clk); check("t3_irq_n2", irq, 1);
    rd_chk("t3_in", 12'h004, 32'h1);
    rd_chk("t3_stat1", 12'h020, 32'h1);
    rd_chk("t3_stat2", 12'h020, 32'h0);
    check("t3_irq_clr", irq, 0);

    // both-edge type, masked, then unmasked
    wr(12'h014, 32'h0);
    wr(12'h01C, 32'h20);
    @(negedge clk); gpio_in[5] = 1'b1;
    repeat (4) @(negedge clk);
    gpio_in[5] = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_irq_masked", irq, 0);
    wr(12'h014, 32'h20);
    check("t4_irq_unmasked", irq, 1);
    rd_chk("t4_stat", 12'h020, 32'h20);
    check("t4_irq_clr", irq, 0);

    // clear-on-read racing a new rise on pin3
    wr(12'h01C, 32'h0);
    wr(12'h014, 32'h0000_000A);
    @(negedge clk); gpio_in[1] = 1'b1; gpio_in[3] = 1'b1;
    @(negedge clk); gpio_in[1] = 1'b0; gpio_in[3] = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk); gpio_in[3] = 1'b1;
    rd_chk("t5_stat_old", 12'h020, 32'h0000_000A);
    rd_chk("t5_stat_kept", 12'h020, 32'h0000_0008);
    check("t5_irq", irq, 0);

    // randomized register traffic
    do_reset();
    m_dir = '0; m_out = '0;
    for (int i = 0; i < NPINS; i++) m_pad[i] = '0;
    repeat (40) begin
      op = $urandom_range(0, 5);
      d  = $urandom;
      k  = $urandom_range(0, NPINS - 1);
      case (op)
        0: begin wr(12'h000, d); m_dir = d; end
        1: begin wr(12'h008, d); m_out = d; end
        2: begin wr(12'h00C, d); m_out = m_out | d; end
        3: begin wr(12'h010, d); m_out = m_out & ~d; end
        4: begin wr(12'(64 + 4 * k), d); m_pad[k] = d[CFG_W-1:0]; end
        default: begin
          rd_chk("rnd_dir", 12'h000, m_dir);
          rd_chk("rnd_out", 12'h008, m_out);
          rd_chk("rnd_pad", 12'(64 + 4 * k), 32'(m_pad[k]));
        end
      endcase
      check("rnd_gpio_out", gpio_out, m_out);
      check("rnd_gpio_dir", gpio_dir, m_dir);
    end
    for (int i = 0; i < NPINS; i++) exp_cfg[i*CFG_W +: CFG_W] = m_pad[i];
    check("rnd_gpio_cfg", gpio_cfg, exp_cfg);

    // randomized pin activity: status = OR of every sampled transition matching its type
    cur = '0;
    repeat (12) begin
      m_inten = $urandom; m_t0 = $urandom; m_t1 = $urandom & $urandom;
      wr(12'h014, m_inten);
      wr(12'h018, m_t0);
      wr(12'h01C, m_t1);
      rd_chk("rnd_stat_pre", 12'h020, 32'h0);
      exp_st = '0;
      pv = cur;
      len = $urandom_range(2, 8);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        v = pv ^ ($urandom & $urandom);
        gpio_in = v;
        rise = v & ~pv;
        fall = ~v & pv;
        for (int p = 0; p < NPINS; p++) begin
          if (m_t1[p]) exp_st[p] = exp_st[p] | rise[p] | fall[p];
          else if (m_t0[p]) exp_st[p] = exp_st[p] | fall[p];
          else exp_st[p] = exp_st[p] | rise[p];
        end
        pv = v;
      end
      cur = pv;
      repeat (3) @(negedge clk);
      check("rnd_irq", irq, |(exp_st & m_inten));
      rd_chk("rnd_in", 12'h004, cur);
      rd_chk("rnd_stat", 12'h020, exp_st);
      rd_chk("rnd_stat_clr", 12'h020, 32'h0);
    end

    do_reset();
    check_idle_zero("reset2");
    rd_chk("reset2_stat", 12'h020, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
